pingpong_display_driver: RTL and testbench

//   Downstream display stage of the ping-pong counter: consumes its 4-bit count and direction
//   and drives the board's 4-digit multiplexed 7-segment display (active-low anodes/segments).
//   AN1:AN0 show the count in decimal (00..15); AN3:AN2 show direction ("uP" = up, "dn" = down).

---
 rtl/pingpong_display_driver_pkg.sv | 28 ++
 rtl/pingpong_display_driver_seg7_decoder.sv | 28 ++
 rtl/pingpong_display_driver.sv | 117 +++++++++++
 tb/tb_pingpong_display_driver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pingpong_display_driver_pkg.sv
// Shared constants for the ping-pong display stage: active-low segment
// patterns {g,f,e,d,c,b,a}, digit slot index type, and the all-anodes-off value.
package pingpong_disp_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_U     = 7'b1100011;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // BCD code that the decoder turns into a dark digit
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/pingpong_display_driver_seg7_decoder.sv
// seg7_decoder: combinational BCD digit to active-low 7-segment pattern.
// Codes 10..15 produce a dark digit.
module seg7_decoder
  import pingpong_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Straight lookup; non-decimal codes blank the digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/pingpong_display_driver.sv
// pingpong_display_driver: scans a 4-digit multiplexed 7-segment display.
// AN1:AN0 show the snapshotted count in decimal, AN3:AN2 show "uP" or "dn".
// Inputs are snapshotted once per frame so a digit never tears mid-scan.
// Each slot starts with BLANK_CYC cycles of all anodes off to avoid ghosting.
// Optional macro PPD_LEADING_ZERO_BLANK_EN: tens digit is dark when count < 10.
module pingpong_display_driver
  import pingpong_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  input  logic       dir_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] refresh_cnt;
  digit_idx_t    digit_idx;
  logic [3:0]    snap_count;
  logic          snap_dir;
  logic          first_slot;

  logic          slot_end, frame_end, in_blank, snap_load;
  logic [1:0][3:0] dig_bcd;   // [0] ones, [1] tens
  logic [1:0][6:0] dig_seg;
  logic [6:0]    seg_next;

  assign slot_end  = (refresh_cnt == SLOT_LAST);
  assign frame_end = slot_end && (digit_idx == 2'd3);
  assign in_blank  = (refresh_cnt < BLANK_LIM);
  // First slot after reset also loads, so the display never shows reset junk
  assign snap_load = first_slot || frame_end;

  // Slot timer and digit scan position
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      first_slot  <= 1'b1;
    end else begin
      first_slot <= 1'b0;
      if (slot_end) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  // Frame-level input snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_count <= 4'd0;
      snap_dir   <= 1'b1;
    end else if (snap_load) begin
      snap_count <= count_in;
      snap_dir   <= dir_in;
    end
  end

  // Split 0..15 into tens/ones with a compare and subtract
  always_comb begin
    dig_bcd[0] = snap_count;
    dig_bcd[1] = 4'd0;
    if (snap_count >= 4'd10) begin
      dig_bcd[0] = snap_count - 4'd10;
      dig_bcd[1] = 4'd1;
    end
`ifdef PPD_LEADING_ZERO_BLANK_EN
    else begin
      dig_bcd[1] = BCD_BLANK;
    end
`endif
  end

  for (genvar g = 0; g < 2; g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd (dig_bcd[g]),
      .seg (dig_seg[g])
    );
  end

  // Pattern for the slot being scanned; letters come straight from the package
  always_comb begin
    seg_next = SEG_BLANK;
    case (digit_idx)
      2'd0: seg_next = dig_seg[0];
      2'd1: seg_next = dig_seg[1];
      2'd2: seg_next = snap_dir ? SEG_P : SEG_N;
      2'd3: seg_next = snap_dir ? SEG_U : SEG_D;
      default: seg_next = SEG_BLANK;
    endcase
  end

  // Registered outputs; seg is preloaded during blanking so it is settled at anode-on
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= in_blank ? AN_OFF : ~(4'b0001 << digit_idx);
      seg <= seg_next;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_display_driver.sv
// Scoreboard bench for pingpong_display_driver (REFRESH_DIV=4, BLANK_CYC=1).
// A frame-level reference model pushes the expected display per cycle; a
// monitor pops and compares on the falling edge.
module tb_pingpong_display_driver;

  localparam int R     = 4;
  localparam int B     = 1;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic       dir_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  pingpong_display_driver #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .dir_in   (dir_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    bit         chk_seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   t = 0;        // edges since reset release
  int   m_cnt = 0;
  bit   m_dir = 1'b1;

  function automatic logic [6:0] digit_pat(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] slot_pat(int slot, int val, bit dir);
    case (slot)
      0: return digit_pat(val % 10);
`ifdef PPD_LEADING_ZERO_BLANK_EN
      1: return (val < 10) ? 7'b1111111 : digit_pat(val / 10);
`else
      1: return digit_pat(val / 10);
`endif
      2: return dir ? 7'b0001100 : 7'b0101011;
      default: return dir ? 7'b1100011 : 7'b0100001;
    endcase
  endfunction

  // Reference model: time within frame decides slot/blanking; inputs are
  // captured at the first edge after reset and at every frame's last edge.
  initial begin
    exp_t e;
    int   r, idx;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = '{an: 4'b1111, seg: 7'b1111111, chk_seg: 1'b1};
        t = 0;
      end else begin
        r   = t % R;
        idx = (t / R) % 4;
        if (r < B) e = '{an: 4'b1111, seg: 7'b1111111, chk_seg: 1'b0};
        else       e = '{an: ~(4'(1) << idx), seg: slot_pat(idx, m_cnt, m_dir), chk_seg: 1'b1};
        if (t == 0 || (t % FRAME) == FRAME - 1) begin
          m_cnt = int'(count_in);
          m_dir = dir_in;
        end
        t++;
      end
      q.push_back(e);
    end
  end

  // Monitor: compare every presented output against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (an !== e.an || dp !== 1'b1 || (e.chk_seg && seg !== e.seg)) begin
          errors++;
          $display("FAIL disp t=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=1 (seg checked=%0d)",
                   t, an, seg, dp, e.an, e.seg, e.chk_seg);
        end
        checks++;
        if ($countones(~an) > 1) begin
          errors++;
          $display("FAIL onehot: got an=%b, want at most one anode low", an);
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  pc;
    bit  up;
    rst = 1'b1; count_in = 4'd0; dir_in = 1'b1;
    cycles(3);
    rst = 1'b0;

    // Fixed patterns
    count_in = 4'd7;  dir_in = 1'b1; cycles(2 * FRAME + 3);
    rst = 1'b1; cycles(3); rst = 1'b0;          // mid-scan reset
    cycles(2 * FRAME);
    count_in = 4'd13; dir_in = 1'b0; cycles(3 * FRAME);

    // Change 7 -> 8 during slot 1 of a frame
    count_in = 4'd7; dir_in = 1'b1;
    for (int k = 0; k < 4 * FRAME && (t % FRAME) != R + 1; k++) @(negedge clk);
    cycles(FRAME);
    for (int k = 0; k < 4 * FRAME && (t % FRAME) != R + 1; k++) @(negedge clk);
    count_in = 4'd8; cycles(2 * FRAME);

    // Ping-pong counter sweep 0..15..0
    pc = 0; up = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (k % 5 == 0) begin
        if (up && pc == 15) up = 1'b0;
        else if (!up && pc == 0) up = 1'b1;
        pc = up ? pc + 1 : pc - 1;
      end
      count_in = 4'(pc); dir_in = up;
      @(negedge clk);
    end

    // Random inputs with occasional mid-scan resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) count_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dir_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; cycles(3); rst = 1'b0;
      end
      @(negedge clk);
    end

    // Leading-zero case
    count_in = 4'd5; dir_in = 1'b1; cycles(2 * FRAME);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
